pipeline_hazard_ctrl: RTL and testbench

Pipeline control unit for the 32-bit CPU. It sits beside the decode→execute delay register and sequences it.
- Tracks the destination registers of the instructions in EX and MEM.
- Generates registered forwarding selects for rs1/rs2.
- Inserts load-use bubbles, holds the front end during multi-cycle multiplies, and squashes the wrong-path instruction on a taken branch.

---
 rtl/cpu_ctrl_pkg.sv | 29 ++
 rtl/hazard_tracker_stage.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU pipeline control unit: opcodes, forwarding selects,
// hazard FSM encoding and the forwarding priority helper.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_LOAD   = 6'd10;
  localparam logic [5:0] OP_STORE  = 6'd11;
  localparam logic [5:0] OP_BRANCH = 6'd12;
  localparam logic [5:0] OP_MUL    = 6'd13;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MUL_WAIT   = 2'd2;

  // The younger producer (EX) wins; late_load routes a stalled load's data through the MEM path.
  function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit,
                                          input logic late_load);
    if (ex_hit)
      return FWD_MEM;
    else if (mem_hit)
      return late_load ? FWD_MEM : FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_tracker_stage.sv
// One pipeline tracker entry {valid, rd, we, is_load, is_mul} with clear/load/hold control.
// Clear has priority over load; neither asserted holds the entry.
module hazard_tracker_stage #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  src_valid,
  input  logic [REG_ADDR_W-1:0] src_rd,
  input  logic                  src_we,
  input  logic                  src_is_load,
  input  logic                  src_is_mul,
  output logic                  valid,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  we,
  output logic                  is_load,
  output logic                  is_mul
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid   <= 1'b0;
      rd      <= '0;
      we      <= 1'b0;
      is_load <= 1'b0;
      is_mul  <= 1'b0;
    end else if (clear) begin
      valid   <= 1'b0;
      rd      <= '0;
      we      <= 1'b0;
      is_load <= 1'b0;
      is_mul  <= 1'b0;
    end else if (load) begin
      valid   <= src_valid;
      rd      <= src_rd;
      we      <= src_we;
      is_load <= src_is_load;
      is_mul  <= src_is_mul;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding control beside the decode->execute register.
// Define HAZ_PERF_CNT_EN to add the stall_cycles / flush_count performance counters.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [5:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_register_we,
  input  logic                  branch_taken,
  output logic                  stall_fetch,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic [1:0]            fwd_rs1_sel,
  output logic [1:0]            fwd_rs2_sel
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
`endif
);

  localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  logic [1:0]            state, state_next;
  logic [CNT_W-1:0]      mul_cnt, mul_cnt_next;

  logic                  ex_valid, ex_we, ex_is_load, ex_is_mul;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_valid, mem_we, mem_is_load, mem_is_mul;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  unused_mem_is_mul;

  logic ex_rs1_hit, ex_rs2_hit, mem_rs1_hit, mem_rs2_hit;
  logic id_is_load, id_is_mul, load_use;
  logic advance, issue, late_load;

  assign id_is_load = (id_opcode == OP_LOAD);
  assign id_is_mul  = (id_opcode == OP_MUL);
  assign unused_mem_is_mul = mem_is_mul;

  assign ex_rs1_hit  = ex_valid  && ex_we  && (ex_rd  != '0) && (ex_rd  == id_rs1);
  assign ex_rs2_hit  = ex_valid  && ex_we  && (ex_rd  != '0) && (ex_rd  == id_rs2);
  assign mem_rs1_hit = mem_valid && mem_we && (mem_rd != '0) && (mem_rd == id_rs1);
  assign mem_rs2_hit = mem_valid && mem_we && (mem_rd != '0) && (mem_rd == id_rs2);

  assign load_use = id_valid && ex_is_load && (ex_rs1_hit || ex_rs2_hit);

  // A taken branch outranks the load-use stall because the dependent instruction is discarded.
  always_comb begin
    stall_fetch  = 1'b0;
    stall_id     = 1'b0;
    bubble_ex    = 1'b0;
    flush_id     = 1'b0;
    state_next   = state;
    mul_cnt_next = mul_cnt;
    if (state == ST_MUL_WAIT) begin
      stall_fetch  = 1'b1;
      stall_id     = 1'b1;
      mul_cnt_next = mul_cnt - CNT_W'(1);
      if (mul_cnt <= CNT_W'(1))
        state_next = ST_RUN;
    end else if (branch_taken && !reset) begin
      flush_id   = 1'b1;
      bubble_ex  = 1'b1;
      state_next = ST_RUN;
    end else if (load_use) begin
      stall_fetch = 1'b1;
      stall_id    = 1'b1;
      bubble_ex   = 1'b1;
      state_next  = ST_LOAD_STALL;
    end else if (id_valid && id_is_mul) begin
      state_next   = ST_MUL_WAIT;
      mul_cnt_next = CNT_W'(MUL_CYCLES - 1);
    end else begin
      state_next = ST_RUN;
    end
  end

  assign advance   = (state != ST_MUL_WAIT);
  assign issue     = advance && !bubble_ex;
  assign late_load = (state == ST_LOAD_STALL) && mem_is_load;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_RUN;
      mul_cnt <= '0;
    end else begin
      state   <= state_next;
      mul_cnt <= mul_cnt_next;
    end
  end

  // Selects are captured only when the decode instruction actually moves into EX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_rs1_sel <= FWD_RF;
      fwd_rs2_sel <= FWD_RF;
    end else if (issue) begin
      fwd_rs1_sel <= fwd_pick(id_valid && ex_rs1_hit, id_valid && mem_rs1_hit, late_load);
      fwd_rs2_sel <= fwd_pick(id_valid && ex_rs2_hit, id_valid && mem_rs2_hit, late_load);
    end
  end

  hazard_tracker_stage #(.REG_ADDR_W(REG_ADDR_W)) u_ex_tracker (
    .clock       (clock),
    .reset       (reset),
    .load        (issue && id_valid),
    .clear       (advance && !(issue && id_valid)),
    .src_valid   (id_valid),
    .src_rd      (id_rd),
    .src_we      (id_register_we),
    .src_is_load (id_is_load),
    .src_is_mul  (id_is_mul),
    .valid       (ex_valid),
    .rd          (ex_rd),
    .we          (ex_we),
    .is_load     (ex_is_load),
    .is_mul      (ex_is_mul)
  );

  hazard_tracker_stage #(.REG_ADDR_W(REG_ADDR_W)) u_mem_tracker (
    .clock       (clock),
    .reset       (reset),
    .load        (advance),
    .clear       (1'b0),
    .src_valid   (ex_valid),
    .src_rd      (ex_rd),
    .src_we      (ex_we),
    .src_is_load (ex_is_load),
    .src_is_mul  (ex_is_mul),
    .valid       (mem_valid),
    .rd          (mem_rd),
    .we          (mem_we),
    .is_load     (mem_is_load),
    .is_mul      (mem_is_mul)
  );

  // EX holds the multiply for the whole wait, so no branch can resolve there.
  assert property (@(posedge clock) disable iff (reset)
                   (state == ST_MUL_WAIT) |-> (!branch_taken && ex_is_mul));

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_id && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_id && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MUL_CYCLES=3).
module tb_pipeline_hazard_ctrl;
  import cpu_ctrl_pkg::*;

  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_register_we;
  logic       branch_taken;
  logic       stall_fetch, stall_id, bubble_ex, flush_id;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.MUL_CYCLES(3), .REG_ADDR_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_register_we (id_register_we),
    .branch_taken   (branch_taken),
    .stall_fetch    (stall_fetch),
    .stall_id       (stall_id),
    .bubble_ex      (bubble_ex),
    .flush_id       (flush_id),
    .fwd_rs1_sel    (fwd_rs1_sel),
    .fwd_rs2_sel    (fwd_rs2_sel)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`endif
  );

  task automatic drive_id(input logic v, input logic [5:0] op, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic we);
    id_valid       = v;
    id_opcode      = op;
    id_rs1         = rs1;
    id_rs2         = rs2;
    id_rd          = rd;
    id_register_we = we;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic mid;
    #4;
  endtask

  task automatic idle;
    drive_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    branch_taken = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    branch_taken = 1'b1;
    drive_id(1'b1, OP_LOAD, 5'd7, 5'd7, 5'd7, 1'b1);
    tick();
    checks++; if (stall_fetch !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall_fetch: got %b expected 0", stall_fetch); end
    checks++; if (stall_id !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall_id: got %b expected 0", stall_id); end
    checks++; if (bubble_ex !== 1'b0) begin failures++; $display("[TB] FAIL reset_bubble_ex: got %b expected 0", bubble_ex); end
    checks++; if (flush_id !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush_id: got %b expected 0", flush_id); end
    checks++; if (fwd_rs1_sel !== 2'd0) begin failures++; $display("[TB] FAIL reset_fwd_rs1: got %0d expected 0", fwd_rs1_sel); end
    checks++; if (fwd_rs2_sel !== 2'd0) begin failures++; $display("[TB] FAIL reset_fwd_rs2: got %0d expected 0", fwd_rs2_sel); end
    branch_taken = 1'b0;
    drive_id(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_forward;
    idle();
    drive_id(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b1);
    tick();
    drive_id(1'b1, OP_ADD, 5'd3, 5'd5, 5'd4, 1'b1);
    mid();
    checks++; if (stall_id !== 1'b0) begin failures++; $display("[TB] FAIL fwd_ex_no_stall: got %b expected 0", stall_id); end
    checks++; if (bubble_ex !== 1'b0) begin failures++; $display("[TB] FAIL fwd_ex_no_bubble: got %b expected 0", bubble_ex); end
    tick();
    checks++; if (fwd_rs1_sel !== 2'd1) begin failures++; $display("[TB] FAIL fwd_ex_rs1: got %0d expected 1", fwd_rs1_sel); end
    checks++; if (fwd_rs2_sel !== 2'd0) begin failures++; $display("[TB] FAIL fwd_ex_rs2: got %0d expected 0", fwd_rs2_sel); end
    drive_id(1'b1, OP_ADD, 5'd5, 5'd3, 5'd6, 1'b1);
    tick();
    checks++; if (fwd_rs1_sel !== 2'd0) begin failures++; $display("[TB] FAIL fwd_mem_rs1: got %0d expected 0", fwd_rs1_sel); end
    checks++; if (fwd_rs2_sel !== 2'd2) begin failures++; $display("[TB] FAIL fwd_mem_rs2: got %0d expected 2", fwd_rs2_sel); end
    drive_id(1'b1, OP_ADD, 5'd6, 5'd4, 5'd6, 1'b1);
    tick();
    checks++; if (fwd_rs1_sel !== 2'd1) begin failures++; $display("[TB] FAIL fwd_mix_rs1: got %0d expected 1", fwd_rs1_sel); end
    checks++; if (fwd_rs2_sel !== 2'd2) begin failures++; $display("[TB] FAIL fwd_mix_rs2: got %0d expected 2", fwd_rs2_sel); end
    drive_id(1'b1, OP_ADD, 5'd6, 5'd6, 5'd7, 1'b1);
    tick();
    checks++; if (fwd_rs1_sel !== 2'd1) begin failures++; $display("[TB] FAIL fwd_younger_rs1: got %0d expected 1", fwd_rs1_sel); end
    checks++; if (fwd_rs2_sel !== 2'd1) begin failures++; $display("[TB] FAIL fwd_younger_rs2: got %0d expected 1", fwd_rs2_sel); end
  endtask

  task automatic test_load_use;
    idle();
    drive_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd7, 1'b1);
    mid();
    checks++; if (stall_id !== 1'b0) begin failures++; $display("[TB] FAIL lu_load_no_stall: got %b expected 0", stall_id); end
    tick();
    drive_id(1'b1, OP_SUB, 5'd2, 5'd7, 5'd8, 1'b1);
    mid();
    checks++; if (stall_id !== 1'b1) begin failures++; $display("[TB] FAIL lu_stall_id: got %b expected 1", stall_id); end
    checks++; if (stall_fetch !== 1'b1) begin failures++; $display("[TB] FAIL lu_stall_fetch: got %b expected 1", stall_fetch); end
    checks++; if (bubble_ex !== 1'b1) begin failures++; $display("[TB] FAIL lu_bubble_ex: got %b expected 1", bubble_ex); end
    checks++; if (flush_id !== 1'b0) begin failures++; $display("[TB] FAIL lu_flush_id: got %b expected 0", flush_id); end
    tick();
    mid();
    checks++; if (stall_id !== 1'b0) begin failures++; $display("[TB] FAIL lu_stall_once: got %b expected 0", stall_id); end
    checks++; if (bubble_ex !== 1'b0) begin failures++; $display("[TB] FAIL lu_bubble_once: got %b expected 0", bubble_ex); end
    tick();
    checks++; if (fwd_rs2_sel !== 2'd1) begin failures++; $display("[TB] FAIL lu_fwd_rs2: got %0d expected 1", fwd_rs2_sel); end
    checks++; if (fwd_rs1_sel !== 2'd0) begin failures++; $display("[TB] FAIL lu_fwd_rs1: got %0d expected 0", fwd_rs1_sel); end
  endtask

  task automatic test_mul;
    idle();
    drive_id(1'b1, OP_ADD, 5'd0, 5'd0, 5'd1, 1'b1);
    tick();
    drive_id(1'b1, OP_MUL, 5'd1, 5'd2, 5'd9, 1'b1);
    mid();
    checks++; if (stall_id !== 1'b0) begin failures++; $display("[TB] FAIL mul_issue_no_stall: got %b expected 0", stall_id); end
    tick();
    checks++; if (fwd_rs1_sel !== 2'd1) begin failures++; $display("[TB] FAIL mul_issue_rs1: got %0d expected 1", fwd_rs1_sel); end
    drive_id(1'b1, OP_ADD, 5'd9, 5'd1, 5'd10, 1'b1);
    mid();
    checks++; if (stall_id !== 1'b1) begin failures++; $display("[TB] FAIL mul_wait1_stall_id: got %b expected 1", stall_id); end
    checks++; if (stall_fetch !== 1'b1) begin failures++; $display("[TB] FAIL mul_wait1_stall_fetch: got %b expected 1", stall_fetch); end
    checks++; if (bubble_ex !== 1'b0) begin failures++; $display("[TB] FAIL mul_wait1_bubble: got %b expected 0", bubble_ex); end
    tick();
    checks++; if (fwd_rs2_sel !== 2'd0) begin failures++; $display("[TB] FAIL mul_hold_rs2: got %0d expected 0", fwd_rs2_sel); end
    mid();
    checks++; if (stall_id !== 1'b1) begin failures++; $display("[TB] FAIL mul_wait2_stall_id: got %b expected 1", stall_id); end
    tick();
    mid();
    checks++; if (stall_id !== 1'b0) begin failures++; $display("[TB] FAIL mul_release: got %b expected 0", stall_id); end
    tick();
    checks++; if (fwd_rs1_sel !== 2'd1) begin failures++; $display("[TB] FAIL mul_dep_rs1: got %0d expected 1", fwd_rs1_sel); end
    checks++; if (fwd_rs2_sel !== 2'd2) begin failures++; $display("[TB] FAIL mul_dep_rs2: got %0d expected 2", fwd_rs2_sel); end
  endtask

  task automatic test_branch_over_load;
    idle();
    drive_id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd7, 1'b1);
    tick();
    drive_id(1'b1, OP_SUB, 5'd2, 5'd7, 5'd8, 1'b1);
    branch_taken = 1'b1;
    mid();
    checks++; if (flush_id !== 1'b1) begin failures++; $display("[TB] FAIL br_flush_id: got %b expected 1", flush_id); end
    checks++; if (bubble_ex !== 1'b1) begin failures++; $display("[TB] FAIL br_bubble_ex: got %b expected 1", bubble_ex); end
    checks++; if (stall_id !== 1'b0) begin failures++; $display("[TB] FAIL br_stall_id: got %b expected 0", stall_id); end
    checks++; if (stall_fetch !== 1'b0) begin failures++; $display("[TB] FAIL br_stall_fetch: got %b expected 0", stall_fetch); end
    tick();
    branch_taken = 1'b0;
    mid();
    checks++; if (stall_id !== 1'b0) begin failures++; $display("[TB] FAIL br_after_stall: got %b expected 0", stall_id); end
    tick();
    checks++; if (fwd_rs2_sel !== 2'd2) begin failures++; $display("[TB] FAIL br_no_load_stall_rs2: got %0d expected 2", fwd_rs2_sel); end
  endtask

  task automatic test_rd_zero;
    idle();
    drive_id(1'b1, OP_LOAD, 5'd1, 5'd2, 5'd0, 1'b1);
    tick();
    drive_id(1'b1, OP_ADD, 5'd0, 5'd1, 5'd0, 1'b1);
    mid();
    checks++; if (stall_id !== 1'b0) begin failures++; $display("[TB] FAIL r0_no_stall: got %b expected 0", stall_id); end
    tick();
    drive_id(1'b1, OP_SUB, 5'd0, 5'd0, 5'd5, 1'b1);
    tick();
    checks++; if (fwd_rs1_sel !== 2'd0) begin failures++; $display("[TB] FAIL r0_fwd_rs1: got %0d expected 0", fwd_rs1_sel); end
    checks++; if (fwd_rs2_sel !== 2'd0) begin failures++; $display("[TB] FAIL r0_fwd_rs2: got %0d expected 0", fwd_rs2_sel); end
  endtask

  task automatic test_reset_in_mul;
    idle();
    drive_id(1'b1, OP_ADD, 5'd0, 5'd0, 5'd1, 1'b1);
    tick();
    drive_id(1'b1, OP_MUL, 5'd1, 5'd2, 5'd9, 1'b1);
    tick();
    mid();
    checks++; if (stall_id !== 1'b1) begin failures++; $display("[TB] FAIL rm_in_wait: got %b expected 1", stall_id); end
    reset = 1'b1;
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("[TB] FAIL rm_async_stall_id: got %b expected 0", stall_id); end
    checks++; if (stall_fetch !== 1'b0) begin failures++; $display("[TB] FAIL rm_async_stall_fetch: got %b expected 0", stall_fetch); end
    checks++; if (fwd_rs1_sel !== 2'd0) begin failures++; $display("[TB] FAIL rm_async_rs1: got %0d expected 0", fwd_rs1_sel); end
    tick();
    reset = 1'b0;
    drive_id(1'b1, OP_ADD, 5'd9, 5'd1, 5'd10, 1'b1);
    mid();
    checks++; if (stall_id !== 1'b0) begin failures++; $display("[TB] FAIL rm_after_no_stall: got %b expected 0", stall_id); end
    tick();
    checks++; if (fwd_rs1_sel !== 2'd0) begin failures++; $display("[TB] FAIL rm_after_rs1: got %0d expected 0", fwd_rs1_sel); end
    checks++; if (fwd_rs2_sel !== 2'd0) begin failures++; $display("[TB] FAIL rm_after_rs2: got %0d expected 0", fwd_rs2_sel); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mul();
    test_branch_over_load();
    test_rd_zero();
    test_reset_in_mul();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
